wb_arbiter: RTL

- Arbitrates the single writeback bus (CDB) among four producers: the rename-stage forward path, the ALU reservation station (alu), the load/store queue (lsq) and the CSR unit (csr).
- Drives one registered writeback per cycle to the ROB, RAT and reservation-station wakeup logic.
- The rename forward has no backpressure, so it has fixed top priority. alu/lsq/csr share round-robin priority.
- A starvation counter periodically blocks rename forwarding for one cycle.

---
 rtl/wb_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Arbitrates the single writeback bus (CDB) between the rename-stage forward
//   path and three reservation-station style producers (alu, lsq, csr), and
//   drives one registered writeback per cycle to the ROB / RAT / wakeup logic.
//
//   Priority: rob_flush suppresses everything; otherwise the rename forward
//   (which cannot be back-pressured) always wins; otherwise alu/lsq/csr share
//   round-robin priority (RR_EN=1) or fixed alu > lsq > csr (RR_EN=0).
//   A starvation counter pulses wb_fwd_block for one cycle after STARVE_LIMIT
//   consecutive rename wins with an alu/lsq/csr request waiting.
//
// Ports:
//   clk, rst (synchronous, active-low), rob_flush
//   rename_wb_valid/result[29:0]/robid[6:0]/rd[5:0]   rename forward request
//   {alu,lsq,csr}_wb_valid/robid[6:0]/rd[5:0]/result[31:0]  producer requests
//   {alu,lsq,csr}_wb_ready   combinational grant (transfer = valid & ready)
//   wb_valid/wb_robid/wb_rd/wb_result   registered writeback
//   wb_fwd_block             registered one-cycle rename stall request
// -----------------------------------------------------------------------------

// Simulation-only protocol checks for the arbiter; synthesis ignores them.
module wb_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic rename_wb_valid,
  input logic wb_fwd_block,
  input logic alu_wb_ready,
  input logic lsq_wb_ready,
  input logic csr_wb_ready
);

  // Rename must honour the block pulse; the arbiter still lets it win if not.
  a_fwd_block_contract: assert property (
    @(posedge clk) disable iff (!rst) !(wb_fwd_block && rename_wb_valid));

  // At most one producer is granted in any cycle.
  a_grant_onehot: assert property (
    @(posedge clk) disable iff (!rst)
      $onehot0({alu_wb_ready, lsq_wb_ready, csr_wb_ready}));

endmodule

module wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RR_EN        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_flush,
  input  logic        rename_wb_valid,
  input  logic [29:0] rename_wb_result,
  input  logic [6:0]  rename_robid,
  input  logic [5:0]  rename_rd,
  input  logic        alu_wb_valid,
  input  logic [6:0]  alu_wb_robid,
  input  logic [5:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_result,
  input  logic        lsq_wb_valid,
  input  logic [6:0]  lsq_wb_robid,
  input  logic [5:0]  lsq_wb_rd,
  input  logic [31:0] lsq_wb_result,
  input  logic        csr_wb_valid,
  input  logic [6:0]  csr_wb_robid,
  input  logic [5:0]  csr_wb_rd,
  input  logic [31:0] csr_wb_result,
  output logic        alu_wb_ready,
  output logic        lsq_wb_ready,
  output logic        csr_wb_ready,
  output logic        wb_valid,
  output logic [6:0]  wb_robid,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_result,
  output logic        wb_fwd_block
);

  localparam logic [1:0] PTR_ALU = 2'd0;
  localparam logic [1:0] PTR_LSQ = 2'd1;
  localparam logic [1:0] PTR_CSR = 2'd2;

  // Value of the counter on the rename win that triggers the block pulse.
  localparam logic [2:0] STARVE_LAST = 3'(STARVE_LIMIT - 1);

  typedef enum logic [2:0] {
    WIN_NONE = 3'd0,
    WIN_REN  = 3'd1,
    WIN_ALU  = 3'd2,
    WIN_LSQ  = 3'd3,
    WIN_CSR  = 3'd4
  } win_e;

  logic        wb_valid_q,  wb_valid_d;
  logic [6:0]  wb_robid_q,  wb_robid_d;
  logic [5:0]  wb_rd_q,     wb_rd_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic        fwd_block_q, fwd_block_d;
  logic [1:0]  rr_ptr_q,    rr_ptr_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;

  win_e        win;
  logic [1:0]  ptr_eff;
  logic        pend;

  assign pend = alu_wb_valid | lsq_wb_valid | csr_wb_valid;

  // Pick this cycle's winner; reset and flush suppress every grant.
  always_comb begin
    win = WIN_NONE;
    // Encoding 3 cannot be reached normally but is folded onto ALU.
    if (rr_ptr_q == 2'd3) begin
      ptr_eff = PTR_ALU;
    end else begin
      ptr_eff = rr_ptr_q;
    end

    if (!rst) begin
      win = WIN_NONE;
    end else if (rob_flush) begin
      win = WIN_NONE;
    end else if (rename_wb_valid) begin
      win = WIN_REN;
    end else if (RR_EN != 0) begin
      case (ptr_eff)
        PTR_LSQ: begin
          if (lsq_wb_valid)      win = WIN_LSQ;
          else if (csr_wb_valid) win = WIN_CSR;
          else if (alu_wb_valid) win = WIN_ALU;
          else                   win = WIN_NONE;
        end
        PTR_CSR: begin
          if (csr_wb_valid)      win = WIN_CSR;
          else if (alu_wb_valid) win = WIN_ALU;
          else if (lsq_wb_valid) win = WIN_LSQ;
          else                   win = WIN_NONE;
        end
        default: begin
          if (alu_wb_valid)      win = WIN_ALU;
          else if (lsq_wb_valid) win = WIN_LSQ;
          else if (csr_wb_valid) win = WIN_CSR;
          else                   win = WIN_NONE;
        end
      endcase
    end else begin
      if (alu_wb_valid)      win = WIN_ALU;
      else if (lsq_wb_valid) win = WIN_LSQ;
      else if (csr_wb_valid) win = WIN_CSR;
      else                   win = WIN_NONE;
    end
  end

  assign alu_wb_ready = (win == WIN_ALU);
  assign lsq_wb_ready = (win == WIN_LSQ);
  assign csr_wb_ready = (win == WIN_CSR);

  // Next writeback payload, round-robin pointer and starvation tracking.
  always_comb begin
    wb_valid_d   = 1'b0;
    wb_robid_d   = wb_robid_q;
    wb_rd_d      = wb_rd_q;
    wb_result_d  = wb_result_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = 3'd0;
    fwd_block_d  = 1'b0;

    case (win)
      WIN_REN: begin
        wb_valid_d  = 1'b1;
        wb_robid_d  = rename_robid;
        wb_rd_d     = rename_rd;
        wb_result_d = {rename_wb_result, 2'b00};
      end
      WIN_ALU: begin
        wb_valid_d  = 1'b1;
        wb_robid_d  = alu_wb_robid;
        wb_rd_d     = alu_wb_rd;
        wb_result_d = alu_wb_result;
        rr_ptr_d    = PTR_LSQ;
      end
      WIN_LSQ: begin
        wb_valid_d  = 1'b1;
        wb_robid_d  = lsq_wb_robid;
        wb_rd_d     = lsq_wb_rd;
        wb_result_d = lsq_wb_result;
        rr_ptr_d    = PTR_CSR;
      end
      WIN_CSR: begin
        wb_valid_d  = 1'b1;
        wb_robid_d  = csr_wb_robid;
        wb_rd_d     = csr_wb_rd;
        wb_result_d = csr_wb_result;
        rr_ptr_d    = PTR_ALU;
      end
      default: begin
        wb_valid_d = 1'b0;
      end
    endcase

    // Only a rename win over a waiting producer counts towards starvation;
    // an RS grant, an idle cycle or a flush clears the count.
    if ((win == WIN_REN) && pend) begin
      if (starve_cnt_q == STARVE_LAST) begin
        starve_cnt_d = 3'd0;
        fwd_block_d  = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + 3'd1;
        fwd_block_d  = 1'b0;
      end
    end else begin
      starve_cnt_d = 3'd0;
      fwd_block_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q   <= 1'b0;
      wb_robid_q   <= 7'd0;
      wb_rd_q      <= 6'd0;
      wb_result_q  <= 32'd0;
      fwd_block_q  <= 1'b0;
      rr_ptr_q     <= PTR_ALU;
      starve_cnt_q <= 3'd0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_robid_q   <= wb_robid_d;
      wb_rd_q      <= wb_rd_d;
      wb_result_q  <= wb_result_d;
      fwd_block_q  <= fwd_block_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_robid     = wb_robid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_result    = wb_result_q;
  assign wb_fwd_block = fwd_block_q;

  wb_arbiter_checker u_checker (
    .clk             (clk),
    .rst             (rst),
    .rename_wb_valid (rename_wb_valid),
    .wb_fwd_block    (fwd_block_q),
    .alu_wb_ready    (alu_wb_ready),
    .lsq_wb_ready    (lsq_wb_ready),
    .csr_wb_ready    (csr_wb_ready)
  );

endmodule
